// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: in-order SRAM requests, PC queue and instruction buffer.
// Optional IF_ADEF_CHECK_EN turns a misaligned fetch_pc into an adef entry instead of a fetch.
module if_fetch_unit #(
  parameter int unsigned OUTSTANDING = 2,
  parameter int unsigned IBUF_DEPTH  = 4,
  parameter logic [31:0] RESET_PC    = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_ex,
  input  logic        ertn_flush,
  input  logic        br_taken,
  input  logic [31:0] ex_entry,
  input  logic [31:0] ertn_entry,
  input  logic [31:0] br_target,
  input  logic        br_stall,
  input  logic        id_allowin,
  output logic        if_id_valid,
  output logic [64:0] if_id_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] OutMax  = CW'(OUTSTANDING);
  localparam logic [CW-1:0] IbufMax = CW'(IBUF_DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pcq_q [OUTSTANDING];
  logic [31:0]   pcq_d [OUTSTANDING];
  logic [64:0]   ibuf_q [IBUF_DEPTH];
  logic [64:0]   ibuf_d [IBUF_DEPTH];
  logic [CW-1:0] live_q, live_d, discard_q, discard_d, ibuf_cnt_q, ibuf_cnt_d;
  logic          req_hold_q, req_hold_d, adef_done_q, adef_done_d;

  logic          redirect;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] outstanding, pcq_wr_idx, ibuf_wr_idx;
  logic          can_req, handshake, rsp_valid, rsp_drop, rsp_accept;
  logic          ibuf_pop, ibuf_push, misaligned, adef_push;
  logic [64:0]   ibuf_wdata;

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;
  assign inst_sram_addr  = fetch_pc_q;

  always_comb begin
    redirect    = wb_ex | ertn_flush | br_taken;
    redirect_pc = br_target;
    if (wb_ex) begin
      redirect_pc = ex_entry;
    end else if (ertn_flush) begin
      redirect_pc = ertn_entry;
    end
  end

`ifdef IF_ADEF_CHECK_EN
  // Adef entry waits for older live fetches so decode still sees program order.
  assign misaligned = fetch_pc_q[1:0] != 2'b00;
  assign adef_push  = misaligned & ~adef_done_q & ~redirect & (live_q == '0) &
                      (ibuf_cnt_q < IbufMax);
`else
  assign misaligned = 1'b0;
  assign adef_push  = 1'b0;
`endif

  always_comb begin
    outstanding   = live_q + discard_q;
    can_req       = ~br_stall & (outstanding < OutMax) & ((ibuf_cnt_q + live_q) < IbufMax);
    // A pending request is held until accepted, even if br_stall rises meanwhile.
    inst_sram_req = ~reset & ~redirect & ~misaligned & (req_hold_q | can_req);
    handshake     = inst_sram_req & inst_sram_addr_ok;
    rsp_valid     = inst_sram_data_ok & (outstanding != '0);
    rsp_drop      = rsp_valid & (discard_q != '0);
    rsp_accept    = rsp_valid & (discard_q == '0) & ~redirect;
    if_id_valid   = (ibuf_cnt_q != '0) & ~redirect;
    if_id_bus     = ibuf_q[0];
    ibuf_pop      = if_id_valid & id_allowin;
    ibuf_push     = rsp_accept | adef_push;
    ibuf_wdata    = adef_push ? {1'b1, fetch_pc_q, 32'h0} : {1'b0, pcq_q[0], inst_sram_rdata};
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end else if (handshake) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    req_hold_d  = inst_sram_req & ~inst_sram_addr_ok;
    adef_done_d = ~redirect & (adef_done_q | adef_push);

    discard_d = discard_q;
    if (redirect) begin
      discard_d = outstanding - CW'(rsp_valid);
    end else if (rsp_drop) begin
      discard_d = discard_q - CW'(1);
    end

    pcq_d  = pcq_q;
    live_d = live_q;
    if (rsp_accept) begin
      for (int i = 0; i < int'(OUTSTANDING) - 1; i++) pcq_d[i] = pcq_q[i+1];
      live_d = live_q - CW'(1);
    end
    pcq_wr_idx = live_d;
    if (handshake) begin
      for (int i = 0; i < int'(OUTSTANDING); i++) begin
        if (CW'(i) == pcq_wr_idx) pcq_d[i] = fetch_pc_q;
      end
      live_d = live_d + CW'(1);
    end
    if (redirect) live_d = '0;

    ibuf_d     = ibuf_q;
    ibuf_cnt_d = ibuf_cnt_q;
    if (ibuf_pop) begin
      for (int i = 0; i < int'(IBUF_DEPTH) - 1; i++) ibuf_d[i] = ibuf_q[i+1];
      ibuf_cnt_d = ibuf_cnt_q - CW'(1);
    end
    ibuf_wr_idx = ibuf_cnt_d;
    if (ibuf_push) begin
      for (int i = 0; i < int'(IBUF_DEPTH); i++) begin
        if (CW'(i) == ibuf_wr_idx) ibuf_d[i] = ibuf_wdata;
      end
      ibuf_cnt_d = ibuf_cnt_d + CW'(1);
    end
    if (redirect) ibuf_cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q  <= RESET_PC;
      live_q      <= '0;
      discard_q   <= '0;
      ibuf_cnt_q  <= '0;
      req_hold_q  <= 1'b0;
      adef_done_q <= 1'b0;
      for (int i = 0; i < int'(OUTSTANDING); i++) pcq_q[i] <= '0;
      for (int i = 0; i < int'(IBUF_DEPTH); i++) ibuf_q[i] <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      live_q      <= live_d;
      discard_q   <= discard_d;
      ibuf_cnt_q  <= ibuf_cnt_d;
      req_hold_q  <= req_hold_d;
      adef_done_q <= adef_done_d;
      pcq_q       <= pcq_d;
      ibuf_q      <= ibuf_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a queue-based reference model and SRAM responder.
module tb_if_fetch_unit;
  localparam int Outst = 2;
  localparam int Depth = 4;
  localparam logic [31:0] ResetPc = 32'h1c000000;
  localparam logic [31:0] Missing = 32'hbad0bad1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_ex = 1'b0, ertn_flush = 1'b0, br_taken = 1'b0;
  logic [31:0] ex_entry = '0, ertn_entry = '0, br_target = '0;
  logic        br_stall = 1'b0, id_allowin = 1'b1;
  logic        if_id_valid;
  logic [64:0] if_id_bus;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        addr_ok = 1'b0, data_ok = 1'b0;
  logic [31:0] rdata = '0;

  if_fetch_unit #(
    .OUTSTANDING(Outst),
    .IBUF_DEPTH (Depth),
    .RESET_PC   (ResetPc)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .wb_ex            (wb_ex),
    .ertn_flush       (ertn_flush),
    .br_taken         (br_taken),
    .ex_entry         (ex_entry),
    .ertn_entry       (ertn_entry),
    .br_target        (br_target),
    .br_stall         (br_stall),
    .id_allowin       (id_allowin),
    .if_id_valid      (if_id_valid),
    .if_id_bus        (if_id_bus),
    .inst_sram_req    (inst_sram_req),
    .inst_sram_wr     (inst_sram_wr),
    .inst_sram_size   (inst_sram_size),
    .inst_sram_wstrb  (inst_sram_wstrb),
    .inst_sram_addr   (inst_sram_addr),
    .inst_sram_wdata  (inst_sram_wdata),
    .inst_sram_addr_ok(addr_ok),
    .inst_sram_data_ok(data_ok),
    .inst_sram_rdata  (rdata)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Responder knobs
  int          lat = 1;
  logic [15:0] aok_pat = 16'hffff;
  bit          stray = 1'b0;
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];

  // Reference model state
  logic [31:0] m_pcq[$];
  logic [64:0] m_ibuf[$];
  int          m_discard = 0;
  logic [31:0] m_fetch = ResetPc;
  bit          m_hold = 1'b0;
  bit          m_adef_done = 1'b0;

  logic [31:0] req_log[$];
  logic [64:0] del_log[$];
  int          del_cyc[$];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a0f0f;
  endfunction

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] req_at(input int idx);
    return (idx < req_log.size()) ? req_log[idx] : Missing;
  endfunction

  function automatic logic [64:0] del_at(input int idx);
    return (idx < del_log.size()) ? del_log[idx] : {1'b1, Missing, Missing};
  endfunction

  task automatic model_step();
    bit          redir, exp_req, exp_valid, mis, rsp, adef;
    logic [31:0] tgt;
    int          outst;
    if (reset) begin
      check("req_in_reset", 65'(inst_sram_req), 65'(0));
      check("valid_in_reset", 65'(if_id_valid), 65'(0));
      m_pcq.delete();
      m_ibuf.delete();
      m_discard = 0;
      m_fetch = ResetPc;
      m_hold = 1'b0;
      m_adef_done = 1'b0;
      return;
    end
    redir = wb_ex | ertn_flush | br_taken;
    tgt   = wb_ex ? ex_entry : (ertn_flush ? ertn_entry : br_target);
    outst = m_pcq.size() + m_discard;
`ifdef IF_ADEF_CHECK_EN
    mis = m_fetch[1:0] != 2'b00;
`else
    mis = 1'b0;
`endif
    exp_req = !redir && !mis &&
              (m_hold || (!br_stall && outst < Outst && m_ibuf.size() + m_pcq.size() < Depth));
    exp_valid = (m_ibuf.size() > 0) && !redir;
    check("inst_sram_req", 65'(inst_sram_req), 65'(exp_req));
    if (exp_req) check("inst_sram_addr", 65'(inst_sram_addr), 65'(m_fetch));
    check("if_id_valid", 65'(if_id_valid), 65'(exp_valid));
    if (exp_valid) check("if_id_bus", if_id_bus, m_ibuf[0]);
    check("sram_const", 65'({inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata}),
          65'({1'b0, 2'b10, 4'h0, 32'h0}));
    if (inst_sram_req && addr_ok) req_log.push_back(inst_sram_addr);
    if (if_id_valid && id_allowin) begin
      del_log.push_back(if_id_bus);
      del_cyc.push_back(cyc);
    end

    rsp = data_ok && outst > 0;
    if (redir) begin
      m_discard = outst - (rsp ? 1 : 0);
      m_pcq.delete();
      m_ibuf.delete();
      m_fetch = tgt;
      m_hold = 1'b0;
      m_adef_done = 1'b0;
      return;
    end
    adef = mis && !m_adef_done && m_pcq.size() == 0 && m_ibuf.size() < Depth;
    if (exp_valid && id_allowin) void'(m_ibuf.pop_front());
    if (rsp) begin
      if (m_discard > 0) m_discard--;
      else m_ibuf.push_back({1'b0, m_pcq.pop_front(), rdata});
    end
    if (adef) begin
      m_ibuf.push_back({1'b1, m_fetch, 32'h0});
      m_adef_done = 1'b1;
    end
    if (exp_req && addr_ok) begin
      m_pcq.push_back(m_fetch);
      mem_addr_q.push_back(m_fetch);
      mem_due_q.push_back(cyc + lat);
      m_fetch = m_fetch + 32'd4;
    end
    m_hold = exp_req && !addr_ok;
  endtask

  // Memory side and compare, once per cycle on the falling edge.
  initial forever begin
    @(negedge clk);
    cyc++;
    addr_ok = aok_pat[cyc % 16];
    data_ok = 1'b0;
    rdata   = 32'h0;
    if (reset) begin
      mem_addr_q.delete();
      mem_due_q.delete();
    end else if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
      data_ok = 1'b1;
      rdata   = inst_of(mem_addr_q[0]);
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end else if (stray) begin
      data_ok = 1'b1;
      rdata   = 32'hdeadbeef;
    end
    #1;
    model_step();
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    req_log.delete();
    del_log.delete();
    del_cyc.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic redirect_br(input logic [31:0] t);
    br_target = t;
    br_taken  = 1'b1;
    clear_logs();
    tick(1);
    br_taken  = 1'b0;
  endtask

  initial begin
    // Straight-line fetch, one-cycle latency
    do_reset();
    tick(8);
    check("seq_req0", 65'(req_at(0)), 65'(32'h1c000000));
    check("seq_req1", 65'(req_at(1)), 65'(32'h1c000004));
    check("seq_req2", 65'(req_at(2)), 65'(32'h1c000008));
    check("seq_del0", del_at(0), {1'b0, 32'h1c000000, inst_of(32'h1c000000)});
    check("seq_del1_pc", 65'(del_at(1)[63:32]), 65'(32'h1c000004));
    check("seq_del2_pc", 65'(del_at(2)[63:32]), 65'(32'h1c000008));
    check("seq_continuous", 65'((del_cyc.size() >= 3) ? (del_cyc[2] - del_cyc[0]) : -1), 65'(2));

    // Decode stalled: buffer fills to depth, then drains in order
    id_allowin = 1'b0;
    do_reset();
    tick(10);
    check("full_req_count", 65'(req_log.size()), 65'(4));
    check("full_req_low", 65'(inst_sram_req), 65'(0));
    check("full_valid", 65'(if_id_valid), 65'(1));
    id_allowin = 1'b1;
    tick(6);
    check("drain0", 65'(del_at(0)[63:32]), 65'(32'h1c000000));
    check("drain1", 65'(del_at(1)[63:32]), 65'(32'h1c000004));
    check("drain2", 65'(del_at(2)[63:32]), 65'(32'h1c000008));
    check("drain3", 65'(del_at(3)[63:32]), 65'(32'h1c00000c));

    // Branch with two requests outstanding: both responses dropped
    lat = 4;
    do_reset();
    tick(2);
    check("br_two_out", 65'(req_log.size()), 65'(2));
    redirect_br(32'h1c000100);
    tick(14);
    check("br_first_req", 65'(req_at(0)), 65'(32'h1c000100));
    check("br_first_del", del_at(0), {1'b0, 32'h1c000100, inst_of(32'h1c000100)});

    // wb_ex beats br_taken
    lat = 1;
    do_reset();
    tick(3);
    ex_entry  = 32'h1c008000;
    br_target = 32'h1c000200;
    wb_ex     = 1'b1;
    br_taken  = 1'b1;
    clear_logs();
    tick(1);
    wb_ex     = 1'b0;
    br_taken  = 1'b0;
    tick(6);
    check("prio_req", 65'(req_at(0)), 65'(32'h1c008000));
    check("prio_del", 65'(del_at(0)[63:32]), 65'(32'h1c008000));

    // Reset between addr_ok and data_ok, then a stray data_ok
    lat = 3;
    do_reset();
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    stray = 1'b1;
    clear_logs();
    tick(1);
    stray = 1'b0;
    tick(8);
    check("rst_req0", 65'(req_at(0)), 65'(ResetPc));
    check("rst_del0", del_at(0), {1'b0, ResetPc, inst_of(ResetPc)});
    check("rst_del1", 65'(del_at(1)[63:32]), 65'(32'h1c000004));

    // Wrap modulo 2^32
    lat = 1;
    do_reset();
    tick(2);
    redirect_br(32'hfffffff8);
    tick(6);
    check("wrap_req2", 65'(req_at(2)), 65'(32'h0));
    check("wrap_del2", 65'(del_at(2)[63:32]), 65'(32'h0));

    // Mixed: sparse addr_ok, stalls, decode backpressure, ertn
    lat = 2;
    aok_pat = 16'b1011_0110_1101_0011;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      id_allowin = (i % 5) != 2;
      br_stall   = (i % 7) == 3;
      ertn_entry = 32'h1c004000;
      ertn_flush = (i == 15);
      tick(1);
    end
    ertn_flush = 1'b0;
    br_stall   = 1'b0;
    id_allowin = 1'b1;
    aok_pat    = 16'hffff;
    tick(10);

`ifdef IF_ADEF_CHECK_EN
    // Misaligned redirect: one adef entry, no memory request
    lat = 1;
    do_reset();
    tick(2);
    redirect_br(32'h1c000102);
    tick(6);
    check("adef_no_req", 65'(req_log.size()), 65'(0));
    check("adef_one_del", 65'(del_log.size()), 65'(1));
    check("adef_del", del_at(0), {1'b1, 32'h1c000102, 32'h0});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter OUTSTANDING, default 2: maximum accepted-but-unreturned fetch requests, range 1..4.
REQ-002 SHALL have parameter IBUF_DEPTH, default 4: instruction buffer entries, power of two, at least OUTSTANDING.
REQ-003 SHALL have parameter RESET_PC, default 32'h1c000000: first fetch address after reset.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have ports wb_ex, ertn_flush, br_taken, input, 1 each: redirect strobes, each valid for one cycle.
REQ-007 SHALL have ports ex_entry, ertn_entry, br_target, input, 32 each: redirect targets.
REQ-008 SHALL have port br_stall, input, 1: blocks new requests while high.
REQ-009 SHALL have port id_allowin, input, 1: decode stage accepts this cycle.
REQ-010 SHALL have port if_id_valid, output, 1: buffer head valid toward decode.
REQ-011 SHALL have port if_id_bus, output, 65: {adef, pc[31:0], inst[31:0]}.
REQ-012 SHALL have ports inst_sram_req (out, 1), inst_sram_addr (out, 32), inst_sram_addr_ok (in, 1), inst_sram_data_ok (in, 1) and inst_sram_rdata (in, 32); inst_sram_wr=0, inst_sram_size=2'b10, inst_sram_wstrb=0 and inst_sram_wdata=0 are constant outputs.

Function
REQ-013 SHALL hold fetch_pc; a request handshake is req&addr_ok, drives inst_sram_addr=fetch_pc, and advances fetch_pc by 4, wrapping modulo 2^32.
REQ-014 SHALL assert inst_sram_req only when all hold: no redirect this cycle, br_stall=0, outstanding<OUTSTANDING, and ibuf_count+live_inflight<IBUF_DEPTH.
REQ-015 SHALL keep inst_sram_req and inst_sram_addr stable while req=1 and addr_ok=0, unless a redirect occurs.
REQ-016 SHALL push each request's address into a PC queue of depth OUTSTANDING; on non-discarded data_ok, pop its head and push {pc, rdata} into the instruction buffer.
REQ-017 SHALL return data in request order; data_ok with no outstanding request is ignored.
REQ-018 SHALL drive if_id_valid=(ibuf_count!=0) & no redirect this cycle; the head entry pops when if_id_valid & id_allowin.
REQ-019 SHALL allow a push and a pop in the same cycle when the buffer is full, leaving the count unchanged.
REQ-020 SHALL apply redirect priority wb_ex > ertn_flush > br_taken; the winning target loads fetch_pc next cycle.
REQ-021 SHALL, on redirect, flush the instruction buffer and PC queue, issue no request that cycle, and set discard_cnt to outstanding minus (1 if data_ok this cycle else 0).
REQ-022 SHALL drop data_ok responses while discard_cnt>0, decrementing it; discard_cnt accumulates across back-to-back redirects.
REQ-023 SHALL compute outstanding = live_inflight + discard_cnt, so the cap covers discarded requests too.

Reset
REQ-024 SHALL, on reset, immediately clear ibuf, PC queue and discard_cnt, set fetch_pc=RESET_PC, and force if_id_valid=0 and inst_sram_req=0.
REQ-025 SHALL treat a reset asserted mid-transaction as abandoning all in-flight requests; the memory side is reset simultaneously.

Configuration
REQ-026 SHALL, with IF_ADEF_CHECK_EN defined, treat fetch_pc[1:0]!=0 as follows: issue no memory request, push {adef=1, pc, inst=0} directly when buffer space permits, then stop requesting until a redirect.
REQ-027 SHALL, without IF_ADEF_CHECK_EN, tie adef to 0 and fetch any address unchecked.

Verification
REQ-028 SHALL cover reset, then addr_ok=1 every cycle with data_ok one cycle later: requests 1c000000, 1c000004, 1c000008 issue, and decode receives them in order with if_id_valid continuous.
REQ-029 SHALL cover id_allowin=0 with IBUF_DEPTH=4: exactly 4 entries buffer and req stays low; raising id_allowin drains 1c000000 through 1c00000c without loss.
REQ-030 SHALL cover br_taken to 1c000100 with 2 outstanding: the next 2 data_ok are dropped, and the first delivered pc is 1c000100.
REQ-031 SHALL cover wb_ex (ex_entry=1c008000) and br_taken in the same cycle: fetch resumes at 1c008000.
REQ-032 SHALL cover reset asserted between addr_ok and data_ok: the late data_ok is ignored, and the first fetch is RESET_PC.
REQ-033 SHALL cover, with IF_ADEF_CHECK_EN, a redirect to 1c000102: no memory request, and one entry {adef=1, pc=1c000102} is delivered.
